// File: rtl/uart_tx_fifo.sv
// Purpose: parametrised UART transmitter (5..9 data bits, none/odd/even parity, 1 or 2 stop bits) fed by an internal FIFO.
// Latency: a word pushed into an empty FIFO while idle is popped on the next edge; tx falls right after that pop edge.
// Backpressure: tx_ready is low while the FIFO is full or rst is high; the producer holds tx_valid/tx_data until accepted.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Bit timing: every bit period is CLKS_PER_BIT cycles; the stop period
    // is the longest interval the baud counter has to measure.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int BW           = $clog2(STOP_CLKS);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;
    localparam int NW           = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_CLKS - 1);
    localparam logic [NW-1:0] DATA_LAST  = NW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic          HAS_PARITY = (PARITY != 0);
    localparam logic          ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO: circular buffer, pointers wrap naturally (power-of-two
    // depth). The count is the only flow-control state seen by the FSM
    // and by tx_ready.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [NW-1:0]        bit_cnt;
    logic [BW-1:0]        baud_cnt;
    logic                 par_bit;
    logic                 tx_q;
    logic                 bit_end;
    logic                 stop_end;

    assign head     = mem[rd_ptr];
    assign bit_end  = (baud_cnt == BIT_LAST);
    assign stop_end = (baud_cnt == STOP_LAST);

    // Ready comes from the registered count only, so a pop on this edge
    // cannot make room for a push on the same edge.
    assign tx_ready = !rst && (count < DEPTH_C);
    assign push     = tx_valid && tx_ready;

    // The FSM takes the head word either from idle or at the very end of a
    // stop period, which gives back-to-back frames with no idle gap.
    assign pop = (count != '0) &&
                 ((state == S_IDLE) || ((state == S_STOP) && stop_end));

    assign tx         = tx_q;
    assign fifo_count = count;
    assign busy       = (state != S_IDLE) || (count != '0);

    // FIFO storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy count; reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: drives the registered line value one bit period at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shreg    <= head;
                        par_bit  <= (^head) ^ ODD_PARITY;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        tx_q     <= 1'b0;
                        state    <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                tx_q  <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            // Next bit is the one just above the current LSB.
                            bit_cnt <= bit_cnt + NW'(1);
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                S_STOP: begin
                    if (stop_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg   <= head;
                            par_bit <= (^head) ^ ODD_PARITY;
                            bit_cnt <= '0;
                            tx_q    <= 1'b0;
                            state   <= S_START;
                        end else begin
                            tx_q  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_q     <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose: directed self-checking bench for uart_tx_fifo across several frame formats.
// Latency: every line sample is taken 1 time unit after the rising edge it follows.
// Backpressure: FIFO-full case holds tx_valid until tx_ready returns.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: 8N1, instance B: 8E1, C: 8O1, D: 8N2, E: 7N1. All 10 clk/bit.
    logic [7:0] d_a, d_b, d_c, d_d;
    logic [6:0] d_e;
    logic       v_a, v_b, v_c, v_d, v_e;
    logic       r_a, r_b, r_c, r_d, r_e;
    logic       t_a, t_b, t_c, t_d, t_e;
    logic       b_a, b_b, b_c, b_d, b_e;
    logic [2:0] n_a, n_b, n_c, n_d, n_e;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_a (.clk(clk), .rst(rst), .tx_data(d_a), .tx_valid(v_a), .tx_ready(r_a), .tx(t_a), .busy(b_a), .fifo_count(n_a));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_b (.clk(clk), .rst(rst), .tx_data(d_b), .tx_valid(v_b), .tx_ready(r_b), .tx(t_b), .busy(b_b), .fifo_count(n_b));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_c (.clk(clk), .rst(rst), .tx_data(d_c), .tx_valid(v_c), .tx_ready(r_c), .tx(t_c), .busy(b_c), .fifo_count(n_c));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_d (.clk(clk), .rst(rst), .tx_data(d_d), .tx_valid(v_d), .tx_ready(r_d), .tx(t_d), .busy(b_d), .fifo_count(n_d));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_e (.clk(clk), .rst(rst), .tx_data(d_e), .tx_valid(v_e), .tx_ready(r_e), .tx(t_e), .busy(b_e), .fifo_count(n_e));

    // Monitor mux: the instance under test is picked by sel.
    int         sel;
    logic       tx_mon, busy_mon, rdy_mon;
    logic [2:0] cnt_mon;

    always_comb begin
        tx_mon = t_a; busy_mon = b_a; rdy_mon = r_a; cnt_mon = n_a;
        case (sel)
            1: begin tx_mon = t_b; busy_mon = b_b; rdy_mon = r_b; cnt_mon = n_b; end
            2: begin tx_mon = t_c; busy_mon = b_c; rdy_mon = r_c; cnt_mon = n_c; end
            3: begin tx_mon = t_d; busy_mon = b_d; rdy_mon = r_d; cnt_mon = n_d; end
            4: begin tx_mon = t_e; busy_mon = b_e; rdy_mon = r_e; cnt_mon = n_e; end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  w [6];
    logic [15:0] frm;
    logic        bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int s, input logic v, input logic [7:0] d);
        case (s)
            0: begin v_a = v; d_a = d; end
            1: begin v_b = v; d_b = d; end
            2: begin v_c = v; d_c = d; end
            3: begin v_d = v; d_d = d; end
            default: begin v_e = v; d_e = d[6:0]; end
        endcase
    endtask

    // Checks the line cycle by cycle: bits[i] is the expected level of bit
    // slot i (start at slot 0), each slot 10 cycles; busy must stay high.
    task automatic frame_check(input string tag, input logic [15:0] bits, input int nb, input int first_k);
        for (int k = first_k; k < nb * 10; k++) begin
            chk($sformatf("%s_tx_k%0d", tag, k), 32'(tx_mon), 32'(bits[k / 10]));
            chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy_mon), 1);
            tick();
        end
    endtask

    // One push into an idle instance, then the full frame and the return to idle.
    task automatic single(input int s, input string tag, input logic [7:0] d, input logic [15:0] bits, input int nb);
        sel = s;
        set_in(s, 1'b1, d);
        tick();
        set_in(s, 1'b0, 8'h00);
        chk({tag, "_cnt_after_push"}, 32'(cnt_mon), 1);
        chk({tag, "_busy_after_push"}, 32'(busy_mon), 1);
        chk({tag, "_tx_before_pop"}, 32'(tx_mon), 1);
        tick();
        chk({tag, "_cnt_after_pop"}, 32'(cnt_mon), 0);
        frame_check(tag, bits, nb, 0);
        chk({tag, "_busy_end"}, 32'(busy_mon), 0);
        chk({tag, "_tx_end"}, 32'(tx_mon), 1);
        chk({tag, "_cnt_end"}, 32'(cnt_mon), 0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 0;
        v_a = 1'b0; v_b = 1'b0; v_c = 1'b0; v_d = 1'b0; v_e = 1'b0;
        d_a = '0; d_b = '0; d_c = '0; d_d = '0; d_e = '0;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;

        // Reset state on every instance.
        repeat (3) tick();
        for (int s = 0; s < 5; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst_tx_%0d", s), 32'(tx_mon), 1);
            chk($sformatf("rst_busy_%0d", s), 32'(busy_mon), 0);
            chk($sformatf("rst_cnt_%0d", s), 32'(cnt_mon), 0);
            chk($sformatf("rst_rdy_%0d", s), 32'(rdy_mon), 0);
        end
        rst = 1'b0;
        sel = 0;
        tick();
        tick();
        chk("rdy_after_rst", 32'(rdy_mon), 1);

        // 8N1 0x41: start, 1,0,0,0,0,0,1,0, stop.
        single(0, "a41", 8'h41, 16'b0000_0010_1000_0010, 10);
        // 8E1 0x03: two ones -> parity 0.
        single(1, "even03", 8'h03, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        // 8O1 0x03: parity 1.
        single(2, "odd03", 8'h03, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        // 7N1 0x7F: seven ones, then stop; 90 cycles.
        single(4, "b7_7f", 8'h7F, {7'b0, 1'b1, 7'h7F, 1'b0}, 9);

        // 8N2 back-to-back 0x55 then 0xAA: 20-cycle stop, no gap.
        sel = 3;
        set_in(3, 1'b1, 8'h55);
        tick();
        chk("n2_cnt_1", 32'(cnt_mon), 1);
        set_in(3, 1'b1, 8'hAA);
        tick();
        set_in(3, 1'b0, 8'h00);
        chk("n2_cnt_pushpop", 32'(cnt_mon), 1);
        frame_check("n2_55", {5'b0, 2'b11, 8'h55, 1'b0}, 11, 0);
        chk("n2_cnt_second_pop", 32'(cnt_mon), 0);
        frame_check("n2_aa", {5'b0, 2'b11, 8'hAA, 1'b0}, 11, 0);
        chk("n2_busy_end", 32'(busy_mon), 0);

        // FIFO fill with tx_valid held: 6 words, depth 4.
        sel = 0;
        set_in(0, 1'b1, w[0]);
        tick();
        chk("ff_cnt_e0", 32'(cnt_mon), 1);
        chk("ff_rdy_e0", 32'(rdy_mon), 1);
        set_in(0, 1'b1, w[1]);
        tick();
        chk("ff_tx_pop0", 32'(tx_mon), 0);
        chk("ff_cnt_e1", 32'(cnt_mon), 1);
        set_in(0, 1'b1, w[2]);
        tick();
        chk("ff_cnt_e2", 32'(cnt_mon), 2);
        set_in(0, 1'b1, w[3]);
        tick();
        chk("ff_cnt_e3", 32'(cnt_mon), 3);
        set_in(0, 1'b1, w[4]);
        tick();
        chk("ff_cnt_full", 32'(cnt_mon), 4);
        chk("ff_rdy_full", 32'(rdy_mon), 0);
        set_in(0, 1'b1, w[5]);
        frm = {6'b0, 1'b1, w[0], 1'b0};
        frame_check("ff_f0", frm, 10, 3);
        chk("ff_cnt_pop1", 32'(cnt_mon), 3);
        chk("ff_rdy_pop1", 32'(rdy_mon), 1);
        tick();
        set_in(0, 1'b0, 8'h00);
        chk("ff_cnt_push5", 32'(cnt_mon), 4);
        chk("ff_rdy_push5", 32'(rdy_mon), 0);
        frm = {6'b0, 1'b1, w[1], 1'b0};
        frame_check("ff_f1", frm, 10, 1);
        for (int i = 2; i < 6; i++) begin
            chk($sformatf("ff_cnt_f%0d", i), 32'(cnt_mon), 32'(5 - i));
            frm = {6'b0, 1'b1, w[i], 1'b0};
            frame_check($sformatf("ff_f%0d", i), frm, 10, 0);
        end
        chk("ff_busy_end", 32'(busy_mon), 0);
        chk("ff_cnt_end", 32'(cnt_mon), 0);

        // Reset during data bit 3 of 0x12 with 0x34, 0x56 queued.
        set_in(0, 1'b1, 8'h12);
        tick();
        set_in(0, 1'b1, 8'h34);
        tick();
        set_in(0, 1'b1, 8'h56);
        tick();
        set_in(0, 1'b0, 8'h00);
        chk("mr_cnt_q", 32'(cnt_mon), 2);
        repeat (44) tick();
        chk("mr_tx_bit3", 32'(tx_mon), 0);
        rst = 1'b1;
        tick();
        chk("mr_tx", 32'(tx_mon), 1);
        chk("mr_cnt", 32'(cnt_mon), 0);
        chk("mr_busy", 32'(busy_mon), 0);
        chk("mr_rdy", 32'(rdy_mon), 0);
        rst = 1'b0;
        tick();
        chk("mr_cnt_rel", 32'(cnt_mon), 0);
        bad = 1'b0;
        for (int k = 0; k < 250; k++) begin
            if (tx_mon !== 1'b1 || busy_mon !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("mr_quiet_after", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
